// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, LSB-first,
// one bit per clock under a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             cy;
  logic             last;

  // Full-adder cell on the operand LSBs and the stored carry
  assign s    = a_sr[0] ^ b_sr[0] ^ c;
  assign cy   = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            res   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          c    <= cy;
          res  <= {s, res[WIDTH-1:1]};
          // Counter stops at WIDTH-1; the compare exits SHIFT instead of wrapping
          if (last) begin
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= {s, res[WIDTH-1:1]};
            carry_out <= cy;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases, random ops at WIDTH=8,
// and an exhaustive WIDTH=4 sweep against a half-adder golden model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst, start, busy, done, carry_out;
  logic [7:0] a, b, sum;
  logic       rst4, start4, busy4, done4, carry_out4;
  logic [3:0] a4, b4, sum4;

  int         checks = 0;
  int         passes = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] e8, last8;
  logic [4:0] e4;
  int         busy_run;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(carry_out4)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Golden model: per bit two half adders, carries OR-ed
  function automatic logic [4:0] ha_add(input logic [3:0] x, input logic [3:0] y);
    logic [4:0] r;
    logic [1:0] h1, h2;
    logic       cc;
    cc = 1'b0;
    r  = '0;
    for (int i = 0; i < 4; i++) begin
      h1   = ha(x[i], y[i]);
      h2   = ha(h1[0], cc);
      r[i] = h2[0];
      cc   = h1[1] | h2[1];
    end
    r[4] = cc;
    return r;
  endfunction

  // Monitor for the 8-bit instance: scoreboard pop, hold, exclusivity, busy length
  always @(negedge clk) begin
    if (rst) begin
      last8    = '0;
      busy_run = 0;
    end else begin
      check("busy_done_excl", int'(busy & done), 0);
      if (done) begin
        check("busy_cycles", busy_run, 8);
        busy_run = 0;
        if (q8.size() == 0) begin
          check("unexpected_done", int'({carry_out, sum}), -1);
        end else begin
          e8 = q8.pop_front();
          check("sum8", int'({carry_out, sum}), int'(e8));
        end
        last8 = {carry_out, sum};
      end else begin
        check("hold8", int'({carry_out, sum}), int'(last8));
        if (busy) busy_run++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst4 && done4) begin
      if (q4.size() == 0) begin
        check("unexpected_done4", int'({carry_out4, sum4}), -1);
      end else begin
        e4 = q4.pop_front();
        check("sum4", int'({carry_out4, sum4}), int'(e4));
      end
    end
  end

  task automatic launch(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    q8.push_back({1'b0, x} + {1'b0, y});
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) check(name, 0, 1);
  endtask

  task automatic count_extra(input string name);
    int extra;
    extra = 0;
    repeat (15) begin
      tick();
      if (done) extra++;
    end
    check(name, extra, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] x, y;
    int         n;
    rst = 1'b1; rst4 = 1'b1; start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; a4 = '0; b4 = '0;
    repeat (2) tick();
    rst = 1'b0; rst4 = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_cout", int'(carry_out), 0);
    repeat (20) begin
      tick();
      check("idle_busy", int'(busy), 0);
    end

    launch(8'h5A, 8'h33);
    wait_done("timeout_5a33");
    check("5a33_sum", int'(sum), 8'h8D);
    check("5a33_cout", int'(carry_out), 0);
    tick();

    launch(8'hFF, 8'h01);
    wait_done("timeout_ff01");
    check("ff01_sum", int'(sum), 8'h00);
    check("ff01_cout", int'(carry_out), 1);
    tick();

    launch(8'hFF, 8'hFF);
    wait_done("timeout_ffff");
    check("ffff_sum", int'(sum), 8'hFE);
    check("ffff_cout", int'(carry_out), 1);
    tick();

    // Start while busy must be ignored
    launch(8'h10, 8'h20);
    repeat (2) tick();
    start = 1'b1; a = 8'h01; b = 8'h01;
    tick();
    start = 1'b0;
    wait_done("timeout_busy_start");
    check("busy_start_sum", int'(sum), 8'h30);
    count_extra("busy_start_single_done");

    // Back-to-back: start held high across the done cycle
    start = 1'b1; a = 8'h0F; b = 8'h01;
    q8.push_back(9'h010);
    tick();
    wait_done("timeout_b2b_1");
    check("b2b_sum1", int'(sum), 8'h10);
    q8.push_back(9'h010);
    tick();
    start = 1'b0;
    check("b2b_busy", int'(busy), 1);
    wait_done("timeout_b2b_2");
    check("b2b_sum2", int'(sum), 8'h10);
    tick();

    // Reset mid-operation
    launch(8'hAA, 8'h55);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    q8.delete();
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_sum", int'(sum), 0);
    check("midrst_cout", int'(carry_out), 0);
    tick();
    rst = 1'b0;
    count_extra("midrst_no_done");
    launch(8'hAA, 8'h55);
    wait_done("timeout_aa55");
    check("aa55_sum", int'(sum), 8'hFF);
    check("aa55_cout", int'(carry_out), 0);
    tick();

    repeat (40) begin
      x = 8'($urandom);
      y = 8'($urandom);
      launch(x, y);
      wait_done("timeout_rand");
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();

    // Exhaustive WIDTH=4
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        start4 = 1'b1;
        a4     = 4'(i);
        b4     = 4'(j);
        q4.push_back(ha_add(4'(i), 4'(j)));
        tick();
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
          tick();
          n++;
        end
        if (!done4) check("timeout_w4", 0, 1);
      end
    end
    repeat (3) tick();

    check("q8_empty", q8.size(), 0);
    check("q4_empty", q4.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
